// File: rtl/fft_frame_gen.sv
// fft_frame_gen: frames the ADC sample stream into FRAME_LEN-beat AXI4-Stream
// frames for the FFT core, with an optional inter-frame gap and status flags.
//
// Ports:
//   clk, rst_n          ADC sample clock, async active-low reset
//   ad_data, ad_otr     ADC sample (offset binary) and its over-range flag
//   frame_en            run enable from the learn controller
//   m_tdata/m_tvalid/m_tready/m_tlast   AXI4-Stream master towards xfft
//   frame_done          1-clk pulse after the tlast transfer
//   frame_abort         1-clk pulse when a frame is abandoned
//   otr_seen, overrun   per-frame flags, valid while frame_done=1
//   frame_cnt           completed-frame counter (wraps)
//
// Optional feature macro: FFT_DC_REMOVE_EN
//   defined   -> real part is the sample in two's complement, sign-extended
//   undefined -> real part is the sample zero-extended
module fft_frame_gen #(
    parameter int FRAME_LEN  = 4096,
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  ad_data,
    input  logic        ad_otr,
    input  logic        frame_en,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        frame_done,
    output logic        frame_abort,
    output logic        otr_seen,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [7:0] GAP_INIT =
        (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    gap_q, gap_d;
    logic [15:0]   data_q, data_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic          otr_q, otr_d;
    logic          ovr_q, ovr_d;
    logic [15:0]   fcnt_q, fcnt_d;

    logic          hs;
    logic          stall;
    logic          load;
    logic [CW-1:0] load_idx;
    logic [15:0]   conv;

    assign hs    = valid_q & m_tready;
    assign stall = valid_q & ~m_tready;

`ifdef FFT_DC_REMOVE_EN
    // Flipping the MSB of offset binary gives two's complement.
    assign conv = {{7{~ad_data[9]}}, ad_data[8:0]};
`else
    assign conv = {6'b0, ad_data};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        data_d   = data_q;
        last_d   = last_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        otr_d    = otr_q;
        ovr_d    = ovr_q;
        fcnt_d   = fcnt_q;
        load     = 1'b0;
        load_idx = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (frame_en) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    otr_d   = 1'b0;
                    ovr_d   = 1'b0;
                end
            end
            RUN: begin
                // A sample arriving while the beat is stalled is lost.
                if (stall) begin
                    ovr_d = 1'b1;
                end
                if (hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_q) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 16'd1;
                        cnt_d   = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_INIT;
                        end else if (!frame_en) begin
                            state_d = IDLE;
                        end
                    end else if (frame_en) begin
                        load     = 1'b1;
                        load_idx = cnt_q + 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        abort_d = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (!valid_q) begin
                    if (frame_en) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                // The last gap clock already captures beat 0, so the
                // output stays idle for exactly GAP_CYCLES clocks.
                if (gap_q == 8'd0) begin
                    if (frame_en) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            data_d  = conv;
            last_d  = (load_idx == LAST_IDX);
            valid_d = 1'b1;
            // First beat of a frame restarts the per-frame flags.
            if (!valid_q && cnt_q == '0) begin
                otr_d = ad_otr;
                ovr_d = 1'b0;
            end else begin
                otr_d = otr_q | ad_otr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            otr_q   <= 1'b0;
            ovr_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            otr_q   <= otr_d;
            ovr_q   <= ovr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign m_tdata     = {16'b0, data_q};
    assign m_tvalid    = valid_q;
    assign m_tlast     = last_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign otr_seen    = otr_q;
    assign overrun     = ovr_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_fft_frame_gen.sv
// tb_fft_frame_gen: scoreboard bench for fft_frame_gen (FRAME_LEN=8,
// GAP_CYCLES=2); stimulus pushes expected beats/frame events, a monitor pops.
module tb_fft_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ad_data;
    logic        ad_otr;
    logic        frame_en;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        frame_done;
    logic        frame_abort;
    logic        otr_seen;
    logic        overrun;
    logic [15:0] frame_cnt;

    fft_frame_gen #(
        .FRAME_LEN (8),
        .GAP_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ad_data    (ad_data),
        .ad_otr     (ad_otr),
        .frame_en   (frame_en),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .otr_seen   (otr_seen),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [15:0] cnt;
        logic        otr;
        logic        ovr;
    } done_t;

    beat_t exp_beats[$];
    done_t exp_done[$];
    int    exp_aborts = 0;
    int    n_vec = 0;
    int    n_bad = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    function automatic logic [31:0] exp_word(input logic [9:0] v);
        int s;
`ifdef FFT_DC_REMOVE_EN
        s = int'(v) - 512;
`else
        s = int'(v);
`endif
        return {16'h0, s[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_beat(input logic [9:0] v, input logic l);
        beat_t b;
        b.data = exp_word(v);
        b.last = l;
        exp_beats.push_back(b);
    endtask

    task automatic push_done(input int c, input logic o, input logic v);
        done_t d;
        d.cnt = 16'(c);
        d.otr = o;
        d.ovr = v;
        exp_done.push_back(d);
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < 8; i++) begin
            push_beat(10'(base + i), i == 7);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations on each observed DUT event.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_data", m_tdata, prev_data);
                chk("hold_last", m_tlast, prev_last);
            end
            prev_stall <= m_tvalid && !m_tready;
            prev_data  <= m_tdata;
            prev_last  <= m_tlast;
            if (m_tvalid && m_tready) begin
                if (exp_beats.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL beat: unexpected tdata %h", m_tdata);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    chk("tdata", m_tdata, b.data);
                    chk("tlast", m_tlast, b.last);
                end
            end
            if (frame_done) begin
                if (exp_done.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL done: unexpected pulse cnt %0d",
                             frame_cnt);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("frame_cnt", frame_cnt, d.cnt);
                    chk("otr_seen", otr_seen, d.otr);
                    chk("overrun", overrun, d.ovr);
                end
            end
            if (frame_abort) begin
                n_vec++;
                if (exp_aborts == 0) begin
                    n_bad++;
                    $display("FAIL abort: unexpected pulse got 1 want 0");
                end else begin
                    exp_aborts--;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, m_tvalid, 0);
        chk({tag, "_tdata"}, m_tdata, 0);
        chk({tag, "_tlast"}, m_tlast, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_abort"}, frame_abort, 0);
        chk({tag, "_otr"}, otr_seen, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_fcnt"}, frame_cnt, 0);
    endtask

    logic [9:0] tbl [8];

    initial begin
        rst_n    = 1'b0;
        frame_en = 1'b0;
        ad_data  = '0;
        ad_otr   = 1'b0;
        m_tready = 1'b1;
        repeat (3) step;
        rst_n = 1'b1;
        step;
        chk_all_zero("rst");

        // Ramp: gap skip, stall at beat 4, otr on sample 38, abort.
        push_frame(0);
        push_done(1, 0, 0);
        push_frame(10);
        push_done(2, 0, 0);
        push_beat(10'd20, 0);
        push_beat(10'd21, 0);
        push_beat(10'd22, 0);
        push_beat(10'd23, 0);
        push_beat(10'd24, 0);
        push_beat(10'd28, 0);
        push_beat(10'd29, 0);
        push_beat(10'd30, 1);
        push_done(3, 0, 1);
        push_frame(33);
        push_done(4, 1, 0);
        push_frame(43);
        push_done(5, 0, 0);
        for (int i = 53; i < 57; i++) begin
            push_beat(10'(i), 0);
        end
        exp_aborts = 1;

        frame_en = 1'b1;
        step;
        for (int k = 0; k < 64; k++) begin
            ad_data  = 10'(k);
            ad_otr   = (k == 38);
            m_tready = !((k >= 25 && k <= 27) || k == 57 || k == 58);
            frame_en = (k < 57);
            step;
        end
        chk("cnt_after_abort", frame_cnt, 5);
        chk("idle_tvalid", m_tvalid, 0);

        // Sample conversion on boundary codes.
        tbl[0] = 10'd512;
        tbl[1] = 10'd0;
        tbl[2] = 10'd1023;
        for (int i = 3; i < 8; i++) begin
            tbl[i] = 10'(i);
        end
`ifdef FFT_DC_REMOVE_EN
        chk("conv_512", exp_word(tbl[0]), 32'h0000_0000);
        chk("conv_0", exp_word(tbl[1]), 32'h0000_FE00);
        chk("conv_1023", exp_word(tbl[2]), 32'h0000_01FF);
`endif
        for (int i = 0; i < 8; i++) begin
            push_beat(tbl[i], i == 7);
        end
        push_done(6, 0, 0);
        m_tready = 1'b1;
        ad_otr   = 1'b0;
        frame_en = 1'b1;
        step;
        for (int k = 0; k < 10; k++) begin
            ad_data = (k < 8) ? tbl[k] : 10'd0;
            step;
        end
        frame_en = 1'b0;
        repeat (4) step;
        chk("gap_to_idle", m_tvalid, 0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) begin
            push_beat(10'(100 + i), 0);
        end
        frame_en = 1'b1;
        step;
        for (int k = 0; k < 6; k++) begin
            ad_data = 10'(100 + k);
            step;
        end
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        step;
        step;
        rst_n = 1'b1;
        chk("post_rst_fcnt", frame_cnt, 0);
        chk("post_rst_tvalid", m_tvalid, 0);
        push_frame(200);
        push_done(1, 0, 0);
        step;
        for (int k = 0; k < 10; k++) begin
            ad_data = 10'(200 + k);
            step;
        end
        frame_en = 1'b0;
        repeat (4) step;

        chk("beats_left", exp_beats.size(), 0);
        chk("done_left", exp_done.size(), 0);
        chk("aborts_left", exp_aborts, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_gen.md
Name: fft_frame_gen

Overview:
- Frames the continuous 10-bit ADC sample stream into fixed-length AXI4-Stream frames for the FFT core's s_axis_data channel.
- Generates tdata, tvalid and tlast for each frame.
- Reports frame completion, ADC over-range and dropped-sample status to the learn-control stage.
- Sits between the ADC pins and xfft_0, in the ADC sample clock domain, gated by the learn controller's fft_valid.

Parameters:
- FRAME_LEN, 4096, samples per frame (power of two, 8..65536); tlast accompanies transfer FRAME_LEN-1.
- GAP_CYCLES, 0, idle clocks inserted after each frame before re-arming (0..255).

Ports:
- clk  input  1  ADC sample clock (clk_1_6384m at top level).
- rst_n  input  1  asynchronous active-low reset.
- ad_data  input  10  ADC sample, offset binary.
- ad_otr  input  1  ADC over-range flag for the same sample.
- frame_en  input  1  run enable (fft_valid from the learn controller).
- m_tdata  output  32  FFT input word; imaginary part [31:16] = 0, real part in [15:0].
- m_tvalid  output  1  AXI-S valid.
- m_tready  input  1  AXI-S ready from the FFT core.
- m_tlast  output  1  last sample of the frame.
- frame_done  output  1  one-cycle pulse after the last transfer.
- frame_abort  output  1  one-cycle pulse when a frame is abandoned.
- otr_seen  output  1  at least one sample of the completed frame had ad_otr=1; valid while frame_done=1.
- overrun  output  1  at least one ADC sample was dropped during the completed frame; valid while frame_done=1.
- frame_cnt  output  16  completed-frame counter; wraps 65535->0.

Behaviour:
- Reset values: all outputs 0; state IDLE; sample_cnt 0.
- States: IDLE, RUN, GAP.
- IDLE:
  - m_tvalid=0.
  - When frame_en=1 -> RUN next cycle; sample_cnt=0; per-frame flags cleared.
- RUN:
  - Each clk in which the output register is empty or a handshake occurs (m_tvalid&m_tready), load the current ad_data into the output register and set m_tvalid=1.
  - Sample-to-output latency is 1 clk.
  - While m_tvalid=1 and m_tready=0: m_tdata, m_tlast and m_tvalid are held stable (AXI-S rule).
    - Each ADC sample arriving during the stall is discarded and the overrun flag is set.
    - Samples are never queued.
  - On each handshake, sample_cnt increments.
  - m_tlast=1 exactly when the registered beat is index FRAME_LEN-1.
  - ad_otr is registered alongside the sample; otr_seen accumulates it from accepted samples only.
- End of frame:
  - Handshake with m_tlast=1 -> frame_done=1 for 1 clk, frame_cnt++, m_tvalid=0.
  - otr_seen and overrun hold their frame values during that pulse and clear when the next frame starts.
  - Then -> GAP if GAP_CYCLES>0, else -> RUN directly if frame_en=1, else -> IDLE.
- GAP:
  - m_tvalid=0 for exactly GAP_CYCLES clks.
  - Then -> RUN if frame_en=1, else -> IDLE.
- frame_en falls in RUN:
  - If m_tvalid=0 -> IDLE immediately.
  - Else the pending beat is held until its handshake. No new sample is loaded; that beat's m_tlast follows the normal index rule.
  - After that handshake -> IDLE, with frame_abort=1 for 1 clk.
  - frame_cnt is not incremented and frame_done is not asserted, unless that beat was the tlast beat, in which case normal completion applies and there is no abort.
- frame_en rises during GAP: takes effect only when GAP ends.
- Width rule (default): m_tdata = {22'b0, ad_data}.
- sample_cnt width = clog2(FRAME_LEN); no wrap occurs inside a frame.
- Asynchronous reset mid-frame: everything returns to reset values immediately; no pulses are generated.

Optional Feature:
- Macro: FFT_DC_REMOVE_EN.
- Defined: the sample is converted to two's complement by inverting ad_data[9] and sign-extending to 16 bits in m_tdata[15:0].
  - Example: 512 -> 0x0000; 0 -> 0xFE00; 1023 -> 0x01FF.
  - m_tdata[31:16]=0.
  - Latency is unchanged (conversion happens in the same output register).
- Not defined: zero-extension as in the width rule.

Test Plan:
1. FRAME_LEN=8, GAP_CYCLES=2, m_tready=1, frame_en=1, ad_data ramp 0,1,2...
   -> m_tdata 0..7 with tlast on 7; frame_done pulse; m_tvalid=0 for 2 clks; next frame starts at value 10 (samples 8 and 9 skipped during the gap); frame_cnt=1.
2. m_tready=0 for 3 clks at beat 4 of a ramp.
   -> beat 4 held stable; 3 samples dropped; frame continues with sample 4+4=8; overrun=1 at frame_done; frame still 8 beats with tlast.
3. ad_otr=1 on sample 5 only.
   -> otr_seen=1 at frame_done; cleared in the next frame, which shows otr_seen=0.
4. frame_en dropped at beat 3 with m_tready=0 for 2 clks.
   -> beat 3 held; IDLE after its handshake; frame_abort pulse; frame_cnt unchanged; frame_done=0.
5. FFT_DC_REMOVE_EN defined, samples 512, 0, 1023.
   -> m_tdata 0x00000000, 0x0000FE00, 0x000001FF.
6. rst_n asserted at beat 5, released 2 clks later with frame_en=1.
   -> all outputs 0 during reset; first beat after release is index 0; frame_cnt=0.
